// File: rtl/wb_port_sequencer_pkg.sv
// rtl/wb_port_sequencer_pkg.sv - shared codes and state encoding for the writeback port sequencer
package wb_port_sequencer_pkg;

    typedef enum logic [2:0] {
        WBC_ALU_R  = 3'd0,
        WBC_ALU_I  = 3'd1,
        WBC_LOAD   = 3'd2,
        WBC_JAL    = 3'd3,
        WBC_PUSH   = 3'd4,
        WBC_POP    = 3'd5,
        WBC_RS_UPD = 3'd6,
        WBC_NONE   = 3'd7
    } wb_class_e;

    localparam logic [2:0] RD_RT = 3'b000;
    localparam logic [2:0] RD_RD = 3'b001;
    localparam logic [2:0] RD_RA = 3'b010;
    localparam logic [2:0] RD_SP = 3'b011;
    localparam logic [2:0] RD_RS = 3'b100;

    localparam logic [1:0] WS_ALU    = 2'b00;
    localparam logic [1:0] WS_MEM    = 2'b01;
    localparam logic [1:0] WS_PC4    = 2'b10;
    localparam logic [1:0] WS_SP_ADJ = 2'b11;

    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [4:0] REG_SP = 5'd29;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_WB1      = 3'd2,
        ST_WB2      = 3'd3,
        ST_FIN      = 3'd4
    } wb_state_e;

    // Register index the destination mux will actually select for a given code.
    function automatic logic [4:0] dst_index(input logic [2:0] sel, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] rs);
        case (sel)
            RD_RD:   return rd;
            RD_RA:   return REG_RA;
            RD_SP:   return REG_SP;
            RD_RS:   return rs;
            default: return rt;
        endcase
    endfunction

endpackage

// File: rtl/wb_mem_timer.sv
// rtl/wb_mem_timer.sv - memory wait counter, held at zero outside WAIT_MEM, flags the last allowed cycle
module wb_mem_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TCNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    output logic o_expired
);

    logic [TCNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + TCNT_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    assign o_expired = i_run && (r_count == TCNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/wb_port_sequencer.sv
// rtl/wb_port_sequencer.sv - writeback port sequencer top; WB_SEQ_PERF_EN adds write/stall counters
module wb_port_sequencer
    import wb_port_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TCNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  wb_class,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs,
    input  logic        mem_ready,
    output logic [2:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic        reg_write,
    output logic        busy,
    output logic        done,
`ifdef WB_SEQ_PERF_EN
    output logic [15:0] wr_count,
    output logic [15:0] stall_count,
`endif
    output logic        timeout_err
);

    wb_state_e r_state;
    wb_state_e w_state_nxt;
    wb_class_e r_class;
    logic [4:0] r_rt;
    logic [4:0] r_rd;
    logic [4:0] r_rs;
    logic       r_timed_out;
    logic       w_in_wait;
    logic       w_expired;
    logic       w_timeout_now;

    assign w_in_wait     = (r_state == ST_WAIT_MEM);
    assign w_timeout_now = w_in_wait && !mem_ready && w_expired;

    wb_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TCNT_W     (TCNT_W)
    ) u_mem_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_run    (w_in_wait),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_class     <= WBC_ALU_R;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Only meaningful during FIN, where it marks a memory abort.
            r_timed_out <= w_timeout_now;
            if (r_state == ST_IDLE && start) begin
                r_class <= wb_class_e'(wb_class);
                r_rt    <= in_rt;
                r_rd    <= in_rd;
                r_rs    <= in_rs;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        reg_dst     = RD_RT;
        wb_src      = WS_ALU;
        reg_write   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        timeout_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    case (wb_class_e'(wb_class))
                        WBC_LOAD, WBC_PUSH, WBC_POP: w_state_nxt = ST_WAIT_MEM;
                        WBC_NONE:                    w_state_nxt = ST_FIN;
                        default:                     w_state_nxt = ST_WB1;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ready) begin
                    w_state_nxt = (r_class == WBC_PUSH) ? ST_WB2 : ST_WB1;
                end else if (w_expired) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_WB1: begin
                case (r_class)
                    WBC_ALU_R:  begin reg_dst = RD_RD; wb_src = WS_ALU; end
                    WBC_ALU_I:  begin reg_dst = RD_RT; wb_src = WS_ALU; end
                    WBC_LOAD:   begin reg_dst = RD_RT; wb_src = WS_MEM; end
                    WBC_JAL:    begin reg_dst = RD_RA; wb_src = WS_PC4; end
                    WBC_RS_UPD: begin reg_dst = RD_RS; wb_src = WS_ALU; end
                    WBC_POP:    begin reg_dst = RD_RT; wb_src = WS_MEM; end
                    default:    begin reg_dst = RD_RT; wb_src = WS_ALU; end
                endcase
                // $zero is never written; $ra/$sp resolve to nonzero indices.
                reg_write   = (r_class != WBC_PUSH) && (r_class != WBC_NONE) &&
                              (dst_index(reg_dst, r_rt, r_rd, r_rs) != 5'd0);
                w_state_nxt = (r_class == WBC_POP) ? ST_WB2 : ST_FIN;
            end
            ST_WB2: begin
                reg_dst     = RD_SP;
                wb_src      = WS_SP_ADJ;
                reg_write   = 1'b1;
                w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                done        = 1'b1;
                timeout_err = r_timed_out;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef WB_SEQ_PERF_EN
    logic [15:0] r_wr_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (reg_write && r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_in_wait && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign wr_count    = r_wr_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: doc/wb_port_sequencer.md
Name: wb_port_sequencer

Overview:
Multicycle writeback controller for the single register-file write port. Takes a decoded writeback class plus the rt/rd/rs fields at instruction issue and sequences reg_dst (select code for the 5-bit destination mux), wb_src and reg_write over one or two write cycles. Waits for memory where required and suppresses writes to register 0. Sits between the main control FSM and the destination mux / register bank.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before aborting (1..255)
TCNT_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  issue pulse; sampled only in IDLE
wb_class  in  3  0 ALU_R, 1 ALU_I, 2 LOAD, 3 JAL, 4 PUSH, 5 POP, 6 RS_UPD, 7 NONE
in_rt  in  5  rt field
in_rd  in  5  rd field
in_rs  in  5  rs field
mem_ready  in  1  memory access complete, single-cycle pulse
reg_dst  out  3  mux select: 000 rt, 001 rd, 010 $ra(31), 011 $sp(29), 100 rs
wb_src  out  2  00 ALU, 01 MEM, 10 PC+4, 11 SP_ADJ
reg_write  out  1  register-file write enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the sequence ends
timeout_err  out  1  one-cycle pulse, coincident with done, on memory timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE; reg_write=0, reg_dst=000, wb_src=00, busy=0, done=0, timeout_err=0, counter=0, latched fields=0.
- States: IDLE, WAIT_MEM, WB1, WB2, FIN. Outputs are a Moore decode of the state plus the latched class/fields.
- IDLE: on start=1, latch wb_class, in_rt, in_rd and in_rs.
  - LOAD, PUSH, POP -> WAIT_MEM.
  - NONE -> FIN.
  - Others -> WB1.
  - start while busy is ignored; no queueing.
- WAIT_MEM: counter increments each cycle from 0.
  - mem_ready=1 -> WB1 (PUSH goes to WB2 directly).
  - counter==MEM_TIMEOUT-1 with mem_ready=0 -> FIN with timeout_err; no write.
  - mem_ready on the timeout cycle wins.
- WB1, one cycle, by class:
  - ALU_R: rd/ALU
  - ALU_I: rt/ALU
  - LOAD: rt/MEM
  - JAL: $ra/PC+4
  - RS_UPD: rs/ALU
  - POP: rt/MEM
  - Next state is WB2 for POP, else FIN.
- WB2: reg_dst=011, wb_src=11, reg_write=1 ($sp update; PUSH and POP only) -> FIN.
- FIN: done=1 for one cycle -> IDLE. busy drops in the following cycle.
- Zero suppression: in WB1, if the resolved index (rt, rd or rs) is 0, reg_write=0. reg_dst and wb_src are still driven. $ra and $sp are never suppressed.
- Latency from the start edge:
  - ALU/JAL/RS_UPD: write in cycle 1, done in cycle 2.
  - LOAD: write 1 cycle after mem_ready, done 1 cycle later.
  - POP: two consecutive writes, then done.
- reg_write is asserted only in WB1/WB2, and never two cycles in a row except for POP.
- Reset mid-sequence aborts immediately. The partially completed write sequence is not resumed.

Optional Feature:
WB_SEQ_PERF_EN
- Defined: adds outputs wr_count[15:0] (reg_write cycles) and stall_count[15:0] (WAIT_MEM cycles).
  - Both saturate at 16'hFFFF.
  - Both clear on reset_n=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - wb_class codes
  - reg_dst codes (RD_RT, RD_RD, RD_RA, RD_SP, RD_RS)
  - wb_src codes
  - register constants 31 and 29
  - state encoding
- Natural sub-module: wb_mem_timer (counter + timeout compare, cleared on entry to WAIT_MEM).
- The FSM stays in the top level.

Test Plan:
- ALU_R, rd=8, start at cycle 0 -> cycle 1: reg_write=1, reg_dst=001, wb_src=00; cycle 2: done=1; cycle 3: busy=0.
- LOAD, rt=5, mem_ready at cycle 4 -> cycle 5: write rt/MEM; cycle 6: done.
- POP, rt=9, mem_ready at cycle 2 -> cycle 3: rt/MEM write; cycle 4: 011/11 write; cycle 5: done.
- ALU_I with rt=0 -> no reg_write pulse, done still in cycle 2. JAL -> reg_dst=010, wb_src=10, write.
- LOAD, mem_ready never arrives, MEM_TIMEOUT=15 -> done and timeout_err in the same cycle, 15 cycles after entering WAIT_MEM, zero writes. start during busy -> ignored.
- reset_n low while in WB1 of POP -> all outputs zero asynchronously; no WB2 write after release.
